// File: rtl/dht11_read_controller_if.sv
// Host-side signal bundle of the DHT11 read controller: request, raw pad level,
// bus enable, status strobes and the published reading.
interface dht11_read_controller_if;
  logic       req;
  logic       dht_in;
  logic       dht_oe;
  logic       busy;
  logic       data_valid;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       error;
  logic [1:0] err_code;

  modport master (
    output req, dht_in,
    input  dht_oe, busy, data_valid, hum_int, hum_dec, temp_int, temp_dec, error, err_code
  );

  modport slave (
    input  req, dht_in,
    output dht_oe, busy, data_valid, hum_int, hum_dec, temp_int, temp_dec, error, err_code
  );
endinterface

// File: rtl/dht11_read_controller.sv
// One DHT11 transaction per request: start pulse, response handshake, 40-bit capture,
// checksum check, then a mandatory hold-off before the next start is allowed.
module dht11_read_controller #(
  parameter int unsigned TICKS_PER_US  = 1,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned BIT_THRESH_US = 50,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned HOLDOFF_US    = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  dht11_read_controller_if.slave  bus
);

  localparam int unsigned MAX_US = (START_LOW_US > HOLDOFF_US) ? START_LOW_US : HOLDOFF_US;
  localparam int unsigned US_W   = $clog2(MAX_US) + 1;
  localparam int unsigned TICK_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  typedef logic [US_W-1:0] us_t;

  localparam us_t                US_SAT      = '1;
  localparam us_t                START_LIM   = us_t'(START_LOW_US - 1);
  localparam us_t                TIMEOUT_LIM = us_t'(TIMEOUT_US - 1);
  localparam us_t                HOLD_LIM    = us_t'(HOLDOFF_US - 1);
  localparam us_t                THRESH      = us_t'(BIT_THRESH_US);
  localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICKS_PER_US - 1);

  typedef enum logic [3:0] {
    IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, FAIL, HOLDOFF
  } state_t;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
  } reading_t;

  state_t            state_q, state_d;
  logic              sync1_q, din_s_q, din_d_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  us_t               us_q, us_d;
  logic [39:0]       shift_q, shift_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  reading_t          rd_q, rd_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              data_valid_q, data_valid_d;
  logic              error_q, error_d;
  logic              dht_oe_q, busy_q;

  logic        us_tick, din_fall, din_rise;
  logic        start_done, timeout, hold_done;
  logic [39:0] shift_next;
  logic [7:0]  sum;
  logic        sum_ok;

  assign din_fall   = !din_s_q && din_d_q;
  assign din_rise   = din_s_q && !din_d_q;
  assign us_tick    = (tick_q == TICK_LAST);
  assign start_done = us_tick && (us_q >= START_LIM);
  assign timeout    = us_tick && (us_q >= TIMEOUT_LIM);
  assign hold_done  = us_tick && (us_q >= HOLD_LIM);

  // Checksum is taken over the frame including the bit being shifted in, so the
  // result is registered on entry to CHECK and the strobe shows during CHECK.
  assign shift_next = {shift_q[38:0], (us_q >= THRESH)};
  assign sum        = shift_next[39:32] + shift_next[31:24] + shift_next[23:16] + shift_next[15:8];
  assign sum_ok     = (sum == shift_next[7:0]);

  // NOTE: every variable gets its default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    rd_d         = rd_q;
    err_code_d   = err_code_q;
    data_valid_d = 1'b0;
    error_d      = 1'b0;
    unique case (state_q)
      IDLE: if (bus.req) begin
        state_d    = START_LOW;
        err_code_d = 2'd0;
        shift_d    = '0;
        bit_cnt_d  = '0;
      end
      START_LOW: if (start_done) state_d = WAIT_RESP;
      WAIT_RESP: begin
        if (din_fall)     state_d = RESP_LOW;
        else if (timeout) begin state_d = FAIL; err_code_d = 2'd1; end
      end
      RESP_LOW: begin
        if (din_rise)     state_d = RESP_HIGH;
        else if (timeout) begin state_d = FAIL; err_code_d = 2'd1; end
      end
      RESP_HIGH: begin
        if (din_fall)     state_d = BIT_LOW;
        else if (timeout) begin state_d = FAIL; err_code_d = 2'd1; end
      end
      BIT_LOW: begin
        if (din_rise)     state_d = BIT_HIGH;
        else if (timeout) begin state_d = FAIL; err_code_d = 2'd2; end
      end
      BIT_HIGH: begin
        if (din_fall) begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd39) begin
            state_d = CHECK;
            if (sum_ok) begin
              rd_d         = reading_t'(shift_next[39:8]);
              data_valid_d = 1'b1;
            end else begin
              err_code_d = 2'd3;
              error_d    = 1'b1;
            end
          end else begin
            state_d = BIT_LOW;
          end
        end else if (timeout) begin
          state_d    = FAIL;
          err_code_d = 2'd2;
        end
      end
      CHECK:   state_d = HOLDOFF;
      FAIL:    state_d = HOLDOFF;
      HOLDOFF: if (hold_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == FAIL) error_d = 1'b1;
  end

  // The microsecond counter restarts on every state change and saturates.
  always_comb begin
    tick_d = tick_q;
    us_d   = us_q;
    if (state_d != state_q) begin
      tick_d = '0;
      us_d   = '0;
    end else if (us_tick) begin
      tick_d = '0;
      if (us_q != US_SAT) us_d = us_q + 1'b1;
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      din_s_q      <= 1'b1;
      din_d_q      <= 1'b1;
      tick_q       <= '0;
      us_q         <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      rd_q         <= '0;
      err_code_q   <= 2'd0;
      data_valid_q <= 1'b0;
      error_q      <= 1'b0;
      dht_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= bus.dht_in;
      din_s_q      <= sync1_q;
      din_d_q      <= din_s_q;
      tick_q       <= tick_d;
      us_q         <= us_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      rd_q         <= rd_d;
      err_code_q   <= err_code_d;
      data_valid_q <= data_valid_d;
      error_q      <= error_d;
      dht_oe_q     <= (state_d == START_LOW);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign bus.dht_oe     = dht_oe_q;
  assign bus.busy       = busy_q;
  assign bus.data_valid = data_valid_q;
  assign bus.error      = error_q;
  assign bus.err_code   = err_code_q;
  assign bus.hum_int    = rd_q.hum_int;
  assign bus.hum_dec    = rd_q.hum_dec;
  assign bus.temp_int   = rd_q.temp_int;
  assign bus.temp_dec   = rd_q.temp_dec;

endmodule

// File: tb/tb_dht11_read_controller.sv
// Directed bench for dht11_read_controller: a behavioural sensor drives the
// open-drain line and a monitor timestamps strobes and the host start pulse.
module tb_dht11_read_controller;

  localparam int unsigned START_LOW_US = 2000;
  localparam int unsigned TIMEOUT_US   = 200;
  localparam int unsigned HOLDOFF_US   = 500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sensor_q = 1'b1;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_valid = 0, n_err = 0, n_both = 0, n_oe = 0;
  int oe_run = 0, oe_width = 0;
  int t_valid = 0, t_err = 0, t_oe_fall = 0, t_busy_fall = 0, t_last_fall = 0;
  logic oe_prev = 1'b0, busy_prev = 1'b0;

  dht11_read_controller_if ifc ();

  assign ifc.dht_in = ifc.dht_oe ? 1'b0 : sensor_q;

  dht11_read_controller #(
    .START_LOW_US (START_LOW_US),
    .TIMEOUT_US   (TIMEOUT_US),
    .HOLDOFF_US   (HOLDOFF_US)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    oe_prev   <= ifc.dht_oe;
    busy_prev <= ifc.busy;
    if (ifc.dht_oe && !oe_prev) begin
      n_oe   <= n_oe + 1;
      oe_run <= 1;
    end else if (ifc.dht_oe) begin
      oe_run <= oe_run + 1;
    end
    if (!ifc.dht_oe && oe_prev) begin
      oe_width  <= oe_run;
      t_oe_fall <= cyc;
    end
    if (!ifc.busy && busy_prev) t_busy_fall <= cyc;
    if (ifc.data_valid) begin n_valid <= n_valid + 1; t_valid <= cyc; end
    if (ifc.error)      begin n_err <= n_err + 1;     t_err <= cyc;   end
    if (ifc.data_valid && ifc.error) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    sensor_q = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 ifc.req = 1'b1;
    @(posedge clk); #1 ifc.req = 1'b0;
  endtask

  // Answers one host start pulse; stall_bits > 0 leaves the line high after that many bits.
  task automatic send_frame(input logic [39:0] frame, input int stall_bits);
    int n;
    n = 0;
    while (!ifc.dht_oe && n < 50) begin @(posedge clk); #1; n++; end
    if (!ifc.dht_oe) begin check("start_seen", 0, 1); return; end
    n = 0;
    while (ifc.dht_oe && n < START_LOW_US + 50) begin @(posedge clk); #1; n++; end
    if (ifc.dht_oe) begin check("start_end", 1, 0); return; end
    hold(1'b1, 20);
    hold(1'b0, 80);
    hold(1'b1, 80);
    for (int i = 0; i < 40; i++) begin
      hold(1'b0, 50);
      hold(1'b1, frame[39-i] ? 70 : 27);
      if (stall_bits != 0 && i == stall_bits - 1) return;
    end
    t_last_fall = cyc;
    hold(1'b0, 50);
    sensor_q = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (ifc.busy && n < 20000) begin @(negedge clk); n++; end
    if (ifc.busy) check(tag, 1, 0);
    repeat (2) @(negedge clk);
  endtask

  logic [39:0] good_frame = {8'h37, 8'h00, 8'h19, 8'h00, 8'h50};
  logic [39:0] bad_frame  = {8'h37, 8'h00, 8'h19, 8'h00, 8'h51};
  int v0, e0, o0;

  initial begin
    ifc.req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_oe", ifc.dht_oe, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_strobes", {ifc.data_valid, ifc.error}, 0);
    check("rst_errcode", ifc.err_code, 0);
    check("rst_bytes", {ifc.hum_int, ifc.hum_dec, ifc.temp_int, ifc.temp_dec}, 0);

    // Good frame
    v0 = n_valid; e0 = n_err;
    pulse_req();
    send_frame(good_frame, 0);
    wait_idle("good_busy_timeout");
    check("good_valid_cnt", n_valid - v0, 1);
    check("good_err_cnt", n_err - e0, 0);
    check("good_oe_width", oe_width, START_LOW_US);
    check("good_latency", t_valid - t_last_fall, 3);
    check("good_hum_int", ifc.hum_int, 55);
    check("good_temp_int", ifc.temp_int, 25);
    check("good_decimals", {ifc.hum_dec, ifc.temp_dec}, 0);
    check("good_errcode", ifc.err_code, 0);

    // Checksum error, then a request pulse during hold-off
    v0 = n_valid; e0 = n_err;
    pulse_req();
    send_frame(bad_frame, 0);
    repeat (53) @(posedge clk);
    check("cks_in_holdoff", ifc.busy, 1);
    o0 = n_oe;
    pulse_req();
    wait_idle("cks_busy_timeout");
    repeat (30) @(negedge clk);
    check("cks_err_cnt", n_err - e0, 1);
    check("cks_valid_cnt", n_valid - v0, 0);
    check("cks_errcode", ifc.err_code, 3);
    check("cks_bytes_kept", {ifc.hum_int, ifc.temp_int}, {8'd55, 8'd25});
    check("holdoff_req_dropped", n_oe - o0, 0);
    check("holdoff_idle", {ifc.busy, ifc.dht_oe}, 0);

    // No sensor: line stays high
    v0 = n_valid; e0 = n_err;
    pulse_req();
    wait_idle("nosensor_busy_timeout");
    check("nosensor_oe_width", oe_width, START_LOW_US);
    check("nosensor_err_cnt", n_err - e0, 1);
    check("nosensor_err_delay", t_err - t_oe_fall, TIMEOUT_US);
    // one FAIL cycle followed by the full hold-off
    check("nosensor_holdoff", t_busy_fall - t_err, HOLDOFF_US + 1);
    check("nosensor_errcode", ifc.err_code, 1);
    check("nosensor_valid_cnt", n_valid - v0, 0);

    // Sensor stalls high after bit 12
    v0 = n_valid; e0 = n_err;
    pulse_req();
    send_frame(good_frame, 12);
    wait_idle("stall_busy_timeout");
    check("stall_err_cnt", n_err - e0, 1);
    check("stall_errcode", ifc.err_code, 2);
    check("stall_valid_cnt", n_valid - v0, 0);

    // Reset during a bit high phase
    v0 = n_valid; e0 = n_err;
    pulse_req();
    send_frame(good_frame, 6);
    repeat (20) @(posedge clk);
    check("rbh_busy_before", ifc.busy, 1);
    check("rbh_bytes_before", ifc.hum_int, 55);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rbh_oe", ifc.dht_oe, 0);
    check("rbh_busy", ifc.busy, 0);
    check("rbh_bytes", {ifc.hum_int, ifc.hum_dec, ifc.temp_int, ifc.temp_dec}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (300) @(negedge clk);
    check("rbh_no_strobes", (n_valid - v0) + (n_err - e0), 0);

    // Reset during the start pulse
    o0 = n_oe;
    pulse_req();
    repeat (100) @(posedge clk);
    check("rsl_oe_before", ifc.dht_oe, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rsl_oe", ifc.dht_oe, 0);
    check("rsl_busy", ifc.busy, 0);
    check("rsl_strobes", {ifc.data_valid, ifc.error, ifc.err_code}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rsl_released", {ifc.dht_oe, ifc.busy}, 0);
    check("rsl_one_start", n_oe - o0, 1);

    check("never_both_strobes", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
